// File: rtl/psa_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial saturating add/sub sequencer.
package psa_pkg;

  localparam int LANE_W    = 4;
  localparam int NUM_LANES = 4;
  localparam int OP_W      = NUM_LANES * LANE_W;

  localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Latched request, viewed lane by lane so the active nibble is a plain index.
  typedef struct packed {
    logic [NUM_LANES-1:0][LANE_W-1:0] a;
    logic [NUM_LANES-1:0][LANE_W-1:0] b;
    logic                             sub;
  } op_t;

  // Saturation value picked by the sign of operand A.
  function automatic logic [LANE_W-1:0] sat_val(input logic neg);
    return neg ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/psa_seq_ctrl_if.sv
// Request/response bundle between the execute stage and the sequencer.
interface psa_seq_ctrl_if;
  import psa_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_a;
  logic [OP_W-1:0]   req_b;
  logic              req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [OP_W-1:0]   rsp_sum;
  logic [NUM_LANES-1:0] rsp_ovfl_mask;
  logic              rsp_error;
  logic              busy;

  // Requester side (execute stage / testbench).
  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_ovfl_mask, rsp_error, busy
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_ovfl_mask, rsp_error, busy
  );
endinterface

// File: rtl/psa_seq_ctrl_lane.sv
// One signed saturating add/sub lane; purely combinational.
module sat_lane_4bit
  import psa_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  output logic [LANE_W-1:0] res,
  output logic              ovfl
);

  logic [LANE_W-1:0] bp;
  logic [LANE_W-1:0] raw;

  // Negate B for subtract, add, then detect signed overflow and clamp.
  // Negating the most negative value wraps back to itself, so that case
  // is judged on A's sign alone: A - (-8) overflows exactly when A >= 0.
  always_comb begin
    bp   = sub ? LANE_W'(~b + LANE_W'(1)) : b;
    raw  = a + bp;
    if (sub && (b == SAT_NEG))
      ovfl = ~a[LANE_W-1];
    else
      ovfl = (a[LANE_W-1] == bp[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
    res  = ovfl ? sat_val(a[LANE_W-1]) : raw;
  end

endmodule

// File: rtl/psa_seq_ctrl.sv
// Sequencer: runs one saturating lane across the operand nibbles, LSB first,
// and hands back the assembled result over a valid/ready response.
module psa_seq_ctrl
  import psa_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  psa_seq_ctrl_if.slave bus
);

  localparam int              CNT_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_LANES - 1);

  state_t                           state, state_nx;
  logic [CNT_W-1:0]                 cnt;
  op_t                              op;
  logic [NUM_LANES-1:0][LANE_W-1:0] sum;
  logic [NUM_LANES-1:0]             mask;

  logic                             req_ready;
  logic                             rsp_valid;
  logic                             busy;
  logic                             accept;
  logic                             lane_last;
  logic [LANE_W-1:0]                lane_res;
  logic                             lane_ovfl;

  assign lane_last = (cnt == CNT_LAST);
  assign accept    = req_ready & bus.req_valid;

  // Single shared lane, fed by the nibble selected by the counter.
  sat_lane_4bit u_lane (
    .a    (op.a[cnt]),
    .b    (op.b[cnt]),
    .sub  (op.sub),
    .res  (lane_res),
    .ovfl (lane_ovfl)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake outputs. DONE returns to IDLE rather than
  // accepting directly, so a new request always waits one extra cycle.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (bus.req_valid) state_nx = RUN;
      end
      RUN: begin
        if (lane_last) state_nx = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, lane counter and per-lane result assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op   <= '0;
      cnt  <= '0;
      sum  <= '0;
      mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op.a   <= bus.req_a;
            op.b   <= bus.req_b;
            op.sub <= bus.req_sub;
            cnt    <= '0;
            sum    <= '0;
            mask   <= '0;
          end
        end
        RUN: begin
          sum[cnt]  <= lane_res;
          mask[cnt] <= lane_ovfl;
          cnt       <= lane_last ? '0 : cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.busy          = busy;
  assign bus.rsp_sum       = sum;
  assign bus.rsp_ovfl_mask = mask;
  assign bus.rsp_error     = |mask;

endmodule

// File: tb/tb_psa_seq_ctrl.sv
// Directed bench for psa_seq_ctrl with an arithmetic reference model and
// an expected-result queue.
module tb_psa_seq_ctrl;

  typedef struct packed {
    logic [15:0] sum;
    logic [3:0]  mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last;

  psa_seq_ctrl_if bus();

  psa_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer signed arithmetic, clamped to [-8, 7] per nibble.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int   sa, sbv, r;
    logic [31:0] rv;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      sa  = $signed(a[i*4 +: 4]);
      sbv = $signed(b[i*4 +: 4]);
      r   = s ? sa - sbv : sa + sbv;
      if (r > 7) begin
        r = 7;
        e.mask[i] = 1'b1;
      end else if (r < -8) begin
        r = -8;
        e.mask[i] = 1'b1;
      end
      rv = r;
      e.sum[i*4 +: 4] = rv[3:0];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request and hold it across the accept edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sub   = s;
    sb.push_back(model(a, b, s));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Called just after the accept edge; counts edges until rsp_valid.
  task automatic wait_rsp();
    int n = 0;
    while (!bus.rsp_valid && n < 20) begin
      chk("run_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 32'd4);
  endtask

  task automatic check_rsp();
    chk("sb_size", sb.size(), 32'd1);
    if (sb.size() != 0) begin
      last = sb.pop_front();
      chk("rsp_sum",   {16'd0, bus.rsp_sum},       {16'd0, last.sum});
      chk("rsp_mask",  {28'd0, bus.rsp_ovfl_mask}, {28'd0, last.mask});
      chk("rsp_error", {31'd0, bus.rsp_error},     {31'd0, |last.mask});
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("post_busy",      {31'd0, bus.busy},      32'd0);
    chk("post_req_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic txn(input logic [15:0] a, input logic [15:0] b, input logic s);
    send(a, b, s);
    wait_rsp();
    check_rsp();
    finish_rsp();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_rsp_sum",   {16'd0, bus.rsp_sum},   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Spec vectors; also pin a couple of constants independent of the model
    txn(16'h1234, 16'h1111, 1'b0);
    chk("t1_const", {16'd0, last.sum}, 32'h2345);
    txn(16'h7777, 16'h1111, 1'b0);
    chk("t2_const", {28'd0, last.mask}, 32'hF);
    txn(16'h7080, 16'h1080, 1'b0);
    chk("t3_const", {12'd0, last.sum, last.mask}, 32'h7080A);
    txn(16'h7008, 16'h8001, 1'b1);
    chk("t4_const", {12'd0, last.sum, last.mask}, 32'h70089);
    txn(16'h0000, 16'h8888, 1'b1);
    chk("t4b_const", {12'd0, last.sum, last.mask}, 32'h7777F);
    txn(16'hFFFF, 16'h8888, 1'b1);  // -1 - (-8) = 7 per lane, no overflow
    txn(16'h8888, 16'h0101, 1'b1);  // alternate lanes underflow

    // Response back-pressure with a competing request waiting
    send(16'h4321, 16'h1234, 1'b1);
    wait_rsp();
    check_rsp();
    bus.req_valid = 1'b1;
    bus.req_a     = 16'h0123;
    bus.req_b     = 16'h7654;
    bus.req_sub   = 1'b0;
    sb.push_back(model(16'h0123, 16'h7654, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("hold_rsp_sum",   {16'd0, bus.rsp_sum},   {16'd0, last.sum});
      chk("hold_rsp_mask",  {28'd0, bus.rsp_ovfl_mask}, {28'd0, last.mask});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("bp_idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("bp_idle_busy",      {31'd0, bus.busy},      32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("bp_accept_busy",    {31'd0, bus.busy},      32'd1);
    wait_rsp();
    check_rsp();
    finish_rsp();

    // Reset in the middle of RUN (counter at lane 2)
    send(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("midrst_busy",      {31'd0, bus.busy},      32'd0);
    chk("midrst_rsp_sum",   {16'd0, bus.rsp_sum},   32'd0);
    chk("midrst_mask",      {28'd0, bus.rsp_ovfl_mask}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    txn(16'h0001, 16'h0001, 1'b0);
    chk("t6_const", {12'd0, last.sum, last.mask}, 32'h00020);

    // A few random operand pairs through the reference model
    for (int i = 0; i < 6; i++) begin
      txn(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
